regfile_write_scheduler: RTL and testbench

//  Shares the WRITE_PORTS write ports of register_file_multiport_BRAM between REQUESTERS writeback sources.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_grant_select.sv | 79 +++++++
 rtl/regfile_write_scheduler.sv | 117 +++++++++++
 tb/tb_regfile_write_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write scheduler.
//   REGF_DATA_WIDTH / REGF_REG_COUNT / REGF_ADDR_WIDTH : default geometry
//   reg_addr_t / reg_data_t                           : one register address / datum
//   STARVE_CNT_W                                      : width of a per-requester starve counter
package regfile_pkg;
    localparam int REGF_DATA_WIDTH = 64;
    localparam int REGF_REG_COUNT  = 256;
    localparam int REGF_ADDR_WIDTH = $clog2(REGF_REG_COUNT);
    localparam int STARVE_CNT_W    = 4;

    typedef logic [REGF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REGF_DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/rr_grant_select.sv
// Combinational grant selection for one cycle.
// The scan visits starving requesters first (lowest index first), then every
// remaining requester circularly from rr_ptr. A valid requester is granted while
// ports remain and its address differs from all addresses already granted.
// Ports:
//   valid       in  : requesters eligible for arbitration
//   addrs       in  : packed request addresses, ADDR_WIDTH per requester
//   rr_ptr      in  : round-robin start index
//   starving    in  : requesters that jump ahead of the round-robin order
//   grant       out : granted requester mask
//   port_idx    out : packed requester index driving each port, in scan order
//   grant_count out : number of grants (ports 0..grant_count-1 are used)
module rr_grant_select #(
    parameter int REQUESTERS  = 8,
    parameter int WRITE_PORTS = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 3
) (
    input  logic [REQUESTERS-1:0]             valid,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0]  addrs,
    input  logic [IDX_W-1:0]                  rr_ptr,
    input  logic [REQUESTERS-1:0]             starving,
    output logic [REQUESTERS-1:0]             grant,
    output logic [IDX_W*WRITE_PORTS-1:0]      port_idx,
    output logic [CNT_W-1:0]                  grant_count
);
    logic [ADDR_WIDTH-1:0] addr_a [REQUESTERS];
    logic [IDX_W-1:0]      idx_a  [WRITE_PORTS];

    for (genvar r = 0; r < REQUESTERS; r++) begin : g_unpack
        assign addr_a[r] = addrs[r*ADDR_WIDTH +: ADDR_WIDTH];
    end

    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_pack
        assign port_idx[p*IDX_W +: IDX_W] = idx_a[p];
    end

    always_comb begin
        int               n;
        int               cand;
        logic [IDX_W-1:0] ci;
        logic             take;
        logic             conflict;
        grant    = '0;
        idx_a    = '{default: '0};
        n        = 0;
        cand     = 0;
        ci       = '0;
        take     = 1'b0;
        conflict = 1'b0;
        // pass 0 picks up starving requesters, pass 1 the round-robin remainder
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < REQUESTERS; j++) begin
                if (pass == 0) begin
                    ci   = IDX_W'(j);
                    take = starving[ci];
                end else begin
                    cand = int'(rr_ptr) + j;
                    if (cand >= REQUESTERS) cand = cand - REQUESTERS;
                    ci   = IDX_W'(cand);
                    take = !starving[ci];
                end
                conflict = 1'b0;
                for (int q = 0; q < REQUESTERS; q++) begin
                    if (grant[q] && addr_a[q] == addr_a[ci]) conflict = 1'b1;
                end
                if (take && valid[ci] && n < WRITE_PORTS && !conflict) begin
                    grant[ci] = 1'b1;
                    for (int p = 0; p < WRITE_PORTS; p++) begin
                        if (p == n) idx_a[p] = ci;
                    end
                    n = n + 1;
                end
            end
        end
        grant_count = CNT_W'(n);
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares WRITE_PORTS register-file write ports between REQUESTERS writeback
// sources: round-robin with starvation aging, same-address duplicates dropped
// within a cycle, grants registered onto wr_en/addr/wr_data one cycle later.
// Optional build macro REGFILE_SCHED_ZERO_REG_EN: address 0 is hard-wired zero,
// so writes to it are accepted at once without using a port or conflict slot.
// Ports:
//   clk, sync_rst (sync, active high), clk_en (low freezes all state)
//   req_valid / req_addr / req_data : packed per-requester write requests
//   req_ready                       : combinational accept, transfer on valid && ready
//   wr_en / addr / wr_data          : registered per-port writes to the register file
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = REGF_DATA_WIDTH,
    parameter int REG_COUNT    = REGF_REG_COUNT,
    parameter int ADDR_WIDTH   = $clog2(REG_COUNT),
    parameter int WRITE_PORTS  = 4,
    parameter int REQUESTERS   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             sync_rst,
    input  logic                             clk_en,
    input  logic [REQUESTERS-1:0]            req_valid,
    input  logic [ADDR_WIDTH*REQUESTERS-1:0] req_addr,
    input  logic [DATA_WIDTH*REQUESTERS-1:0] req_data,
    output logic [REQUESTERS-1:0]            req_ready,
    output logic [WRITE_PORTS-1:0]           wr_en,
    output logic [ADDR_WIDTH*WRITE_PORTS-1:0] addr,
    output logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data
);
    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W = $clog2(WRITE_PORTS + 1);

    logic [IDX_W-1:0]        rr_ptr;
    logic [STARVE_CNT_W-1:0] starve_cnt [REQUESTERS];
    logic [REQUESTERS-1:0]   starving, zero_hit, sel_valid, grant, xfer;
    logic [IDX_W*WRITE_PORTS-1:0] port_idx;
    logic [CNT_W-1:0]        grant_count;
    logic [IDX_W-1:0]        last_idx, rr_next;
    logic                    rr_move, active;
    logic [ADDR_WIDTH-1:0]   addr_a [REQUESTERS];
    logic [DATA_WIDTH-1:0]   data_a [REQUESTERS];
    logic [IDX_W-1:0]        pidx_a [WRITE_PORTS];

    for (genvar r = 0; r < REQUESTERS; r++) begin : g_req
        assign addr_a[r]   = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[r]   = req_data[r*DATA_WIDTH +: DATA_WIDTH];
        assign starving[r] = starve_cnt[r] >= STARVE_CNT_W'(STARVE_LIMIT);
`ifdef REGFILE_SCHED_ZERO_REG_EN
        assign zero_hit[r] = req_valid[r] && (addr_a[r] == '0);
`else
        assign zero_hit[r] = 1'b0;
`endif
    end

    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_port
        assign pidx_a[p] = port_idx[p*IDX_W +: IDX_W];
    end

    assign sel_valid = req_valid & ~zero_hit;
    assign active    = clk_en && !sync_rst;
    assign xfer      = active ? (grant | zero_hit) : '0;
    assign req_ready = xfer;

    rr_grant_select #(
        .REQUESTERS (REQUESTERS),
        .WRITE_PORTS(WRITE_PORTS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) u_sel (
        .valid      (sel_valid),
        .addrs      (req_addr),
        .rr_ptr     (rr_ptr),
        .starving   (starving),
        .grant      (grant),
        .port_idx   (port_idx),
        .grant_count(grant_count)
    );

    // Starving grants occupy the lowest ports, so the highest used port holds
    // the last non-starving grant whenever there is one.
    always_comb begin
        last_idx = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (CNT_W'(p + 1) == grant_count) last_idx = pidx_a[p];
        end
        rr_move = (grant_count != '0) && !starving[last_idx];
        rr_next = (last_idx == IDX_W'(REQUESTERS - 1)) ? '0 : last_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_en   <= '0;
            addr    <= '0;
            wr_data <= '0;
            rr_ptr  <= '0;
            for (int r = 0; r < REQUESTERS; r++) starve_cnt[r] <= '0;
        end else if (clk_en) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                wr_en[p] <= (CNT_W'(p) < grant_count);
                if (CNT_W'(p) < grant_count) begin
                    addr[p*ADDR_WIDTH +: ADDR_WIDTH]    <= addr_a[pidx_a[p]];
                    wr_data[p*DATA_WIDTH +: DATA_WIDTH] <= data_a[pidx_a[p]];
                end
            end
            if (rr_move) rr_ptr <= rr_next;
            for (int r = 0; r < REQUESTERS; r++) begin
                if (!req_valid[r] || xfer[r])
                    starve_cnt[r] <= '0;
                else if (starve_cnt[r] != '1)
                    starve_cnt[r] <= starve_cnt[r] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    localparam int R  = 8;
    localparam int P  = 4;
    localparam int AW = REGF_ADDR_WIDTH;
    localparam int DW = REGF_DATA_WIDTH;
    localparam int SL = 2;

    logic            clk = 1'b0;
    logic            sync_rst;
    logic            clk_en;
    logic [R-1:0]    req_valid;
    logic [AW*R-1:0] req_addr;
    logic [DW*R-1:0] req_data;
    logic [R-1:0]    req_ready;
    logic [P-1:0]    wr_en;
    logic [AW*P-1:0] addr;
    logic [DW*P-1:0] wr_data;

    int checks   = 0;
    int failures = 0;

    int           m_rr;
    int           m_cnt [R];
    logic [P-1:0] m_wr_en;
    reg_addr_t    m_addr [P];
    reg_data_t    m_data [P];
    logic [R-1:0] m_ready;
    logic [R-1:0] last_ready;

    regfile_write_scheduler #(
        .DATA_WIDTH  (DW),
        .REG_COUNT   (REGF_REG_COUNT),
        .ADDR_WIDTH  (AW),
        .WRITE_PORTS (P),
        .REQUESTERS  (R),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic reg_addr_t a_of(input int r);
        return req_addr[r*AW +: AW];
    endfunction

    // Reference: builds the scan order as a list, then grants in order.
    task automatic model_step();
        int        order [$];
        int        ports [$];
        reg_addr_t gad [$];
        int        c;
        int        last_ns;
        bit        dup;
        logic [R-1:0] zero;
        m_ready = '0;
        if (sync_rst) begin
            m_rr    = 0;
            m_wr_en = '0;
            for (int r = 0; r < R; r++) m_cnt[r] = 0;
            for (int p = 0; p < P; p++) begin
                m_addr[p] = '0;
                m_data[p] = '0;
            end
            return;
        end
        if (!clk_en) return;
        zero = '0;
`ifdef REGFILE_SCHED_ZERO_REG_EN
        for (int r = 0; r < R; r++) if (req_valid[r] && a_of(r) == 0) zero[r] = 1'b1;
`endif
        for (int r = 0; r < R; r++) if (m_cnt[r] >= SL) order.push_back(r);
        for (int j = 0; j < R; j++) begin
            c = (m_rr + j) % R;
            if (m_cnt[c] < SL) order.push_back(c);
        end
        foreach (order[i]) begin
            c = order[i];
            if (req_valid[c] && !zero[c] && ports.size() < P) begin
                dup = 0;
                foreach (gad[k]) if (gad[k] == a_of(c)) dup = 1;
                if (!dup) begin
                    ports.push_back(c);
                    gad.push_back(a_of(c));
                    m_ready[c] = 1'b1;
                end
            end
        end
        m_ready = m_ready | zero;
        last_ns = -1;
        foreach (ports[k]) if (m_cnt[ports[k]] < SL) last_ns = ports[k];
        for (int p = 0; p < P; p++) begin
            m_wr_en[p] = (p < ports.size());
            if (p < ports.size()) begin
                m_addr[p] = a_of(ports[p]);
                m_data[p] = req_data[ports[p]*DW +: DW];
            end
        end
        if (last_ns >= 0) m_rr = (last_ns + 1) % R;
        for (int r = 0; r < R; r++) begin
            if (!req_valid[r] || m_ready[r]) m_cnt[r] = 0;
            else if (m_cnt[r] < 15) m_cnt[r] = m_cnt[r] + 1;
        end
    endtask

    // Inputs are changed at posedge+1; ready is sampled at posedge+2,
    // registered outputs at posedge+1 of the following edge.
    task automatic cycle();
        #1;
        model_step();
        last_ready = req_ready;
        chk("req_ready", req_ready, m_ready);
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_wr_en);
        for (int p = 0; p < P; p++) begin
            chk($sformatf("addr%0d", p), addr[p*AW +: AW], m_addr[p]);
            chk($sformatf("data%0d", p), wr_data[p*DW +: DW], m_data[p]);
        end
    endtask

    task automatic set_req(input int r, input logic v, input int a);
        req_valid[r]           = v;
        req_addr[r*AW +: AW]   = AW'(a);
        req_data[r*DW +: DW]   = {$urandom, $urandom};
    endtask

    task automatic new_req(input int r);
        set_req(r, $urandom_range(0, 2) != 0,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7));
    endtask

    initial begin
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        for (int r = 0; r < R; r++) set_req(r, 1'b1, r + 1);

        // reset with all requesters valid
        cycle();
        chk("rst_ready", last_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", addr, 0);

        // full load, distinct addresses 1..8
        sync_rst = 1'b0;
        cycle();
        chk("full0_ready", last_ready, 8'h0F);
        chk("full0_wr_en", wr_en, 4'hF);
        for (int p = 0; p < P; p++) chk($sformatf("full0_addr%0d", p), addr[p*AW +: AW], p + 1);
        for (int r = 0; r < 4; r++) req_valid[r] = 1'b0;
        cycle();
        chk("full1_ready", last_ready, 8'hF0);
        chk("full1_addr0", addr[0 +: AW], 5);

        // same-address conflict, rr_ptr has wrapped to 0
        req_valid = '0;
        set_req(0, 1'b1, 5);
        set_req(1, 1'b1, 5);
        set_req(2, 1'b1, 5);
        set_req(3, 1'b1, 6);
        cycle();
        chk("conf_ready", last_ready, 8'h09);
        chk("conf_wr_en", wr_en, 4'h3);
        chk("conf_addr0", addr[0 +: AW], 5);
        chk("conf_addr1", addr[AW +: AW], 6);

        // starvation: r7 denied twice, then jumps to port 0
        sync_rst = 1'b1;
        cycle();
        sync_rst  = 1'b0;
        req_valid = '0;
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 10 + r);
        set_req(7, 1'b1, 20);
        cycle();
        chk("starve_c0_r7", last_ready[7], 0);
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 30 + r);
        set_req(4, 1'b1, 20);
        set_req(5, 1'b1, 21);
        set_req(6, 1'b1, 22);
        cycle();
        chk("starve_c1_r7", last_ready[7], 0);
        for (int r = 4; r < 7; r++) req_valid[r] = 1'b0;
        set_req(0, 1'b1, 40);
        cycle();
        chk("starve_c2_r7", last_ready[7], 1);
        chk("starve_c2_addr0", addr[0 +: AW], 20);

        // clk_en low with requests pending
        for (int r = 0; r < R; r++) set_req(r, 1'b1, 50 + r);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_ready", last_ready, 0);
        end
        clk_en = 1'b1;
        cycle();

        // address 0 handling
        sync_rst = 1'b1;
        cycle();
        sync_rst  = 1'b0;
        req_valid = '0;
        for (int r = 0; r < 5; r++) set_req(r, 1'b1, r);
        cycle();
`ifdef REGFILE_SCHED_ZERO_REG_EN
        chk("zero_ready", last_ready, 8'h1F);
        chk("zero_wr_en", wr_en, 4'hF);
        chk("zero_addr0", addr[0 +: AW], 1);
`else
        chk("zero_ready", last_ready, 8'h0F);
        chk("zero_wr_en", wr_en, 4'hF);
        chk("zero_addr0", addr[0 +: AW], 0);
`endif

        // randomized traffic; requesters hold until accepted
        for (int r = 0; r < R; r++) new_req(r);
        for (int i = 0; i < 3000; i++) begin
            sync_rst = ($urandom_range(0, 99) == 0);
            clk_en   = ($urandom_range(0, 9) != 0);
            cycle();
            for (int r = 0; r < R; r++) if (!req_valid[r] || m_ready[r]) new_req(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
